// File: rtl/plic_cmd_arbiter.sv
// Round-robin arbiter sharing one PLIC command/response port between num_req_p requesters.
// One transaction in flight; a watchdog answers with an error and drains the late response.
module plic_cmd_arbiter #(
    parameter int unsigned num_req_p    = 2,
    parameter int unsigned addr_width_p = 32,
    parameter int unsigned data_width_p = 32,
    parameter int unsigned timeout_p    = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,

    input  logic [num_req_p-1:0]               req_v_i,
    output logic [num_req_p-1:0]               req_ready_and_o,
    input  logic [num_req_p*addr_width_p-1:0]  req_addr_i,
    input  logic [num_req_p-1:0]               req_wr_en_i,
    input  logic [num_req_p*2-1:0]             req_data_size_i,
    input  logic [num_req_p*data_width_p-1:0]  req_wdata_i,

    output logic [num_req_p-1:0]               resp_v_o,
    input  logic [num_req_p-1:0]               resp_ready_and_i,
    output logic [data_width_p-1:0]            resp_rdata_o,
    output logic                               resp_err_o,

    output logic                               cmd_v_o,
    input  logic                               cmd_ready_and_i,
    output logic [addr_width_p-1:0]            cmd_addr_o,
    output logic                               cmd_wr_en_o,
    output logic [1:0]                         cmd_data_size_o,
    output logic [data_width_p-1:0]            cmd_wdata_o,

    input  logic                               plic_resp_v_i,
    output logic                               plic_resp_ready_and_o,
    input  logic [data_width_p-1:0]            plic_resp_rdata_i,

    output logic [$clog2(num_req_p)-1:0]       grant_id_o
);

    localparam int unsigned id_width_lp    = $clog2(num_req_p);
    localparam int unsigned timer_width_lp = $clog2(timeout_p);

    localparam logic [id_width_lp:0]      num_req_lp  = (id_width_lp+1)'(num_req_p);
    localparam logic [id_width_lp-1:0]    last_id_lp  = id_width_lp'(num_req_p - 1);
    localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_p - 1);

    typedef enum logic [1:0] {StIdle, StCmd, StWait, StResp} state_e;

    state_e                    state_r;
    logic [id_width_lp-1:0]    rr_ptr_r;
    logic [id_width_lp-1:0]    grant_r;
    logic                      drain_r;
    logic [timer_width_lp-1:0] timer_r;
    logic [data_width_p-1:0]   rdata_r;
    logic                      err_r;
    logic [addr_width_p-1:0]   addr_r;
    logic                      wr_en_r;
    logic [1:0]                size_r;
    logic [data_width_p-1:0]   wdata_r;

    logic                      win_v;
    logic [id_width_lp-1:0]    win_id;
    logic [id_width_lp:0]      idx;
    logic [id_width_lp-1:0]    cand;
    logic                      grant_ok;

    // First valid requester at or after rr_ptr_r, wrapping modulo num_req_p.
    always_comb begin
        win_v  = 1'b0;
        win_id = '0;
        idx    = '0;
        cand   = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            idx = {1'b0, rr_ptr_r} + (id_width_lp+1)'(k);
            if (idx >= num_req_lp) begin
                idx = idx - num_req_lp;
            end
            cand = idx[id_width_lp-1:0];
            if (!win_v && req_v_i[cand]) begin
                win_v  = 1'b1;
                win_id = cand;
            end
        end
    end

    // A pending late response blocks new grants so it cannot be misrouted.
    assign grant_ok = (state_r == StIdle) && !drain_r && win_v;

    always_comb begin
        req_ready_and_o = '0;
        if (grant_ok) begin
            req_ready_and_o[win_id] = 1'b1;
        end
    end

    always_comb begin
        resp_v_o = '0;
        if (state_r == StResp) begin
            resp_v_o[grant_r] = 1'b1;
        end
    end

    assign resp_rdata_o          = (state_r == StResp) ? rdata_r : '0;
    assign resp_err_o            = (state_r == StResp) && err_r;
    assign cmd_v_o               = (state_r == StCmd);
    assign cmd_addr_o            = cmd_v_o ? addr_r  : '0;
    assign cmd_wr_en_o           = cmd_v_o && wr_en_r;
    assign cmd_data_size_o       = cmd_v_o ? size_r  : '0;
    assign cmd_wdata_o           = cmd_v_o ? wdata_r : '0;
    assign plic_resp_ready_and_o = (state_r == StWait) || drain_r;
    assign grant_id_o            = grant_r;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r  <= StIdle;
            rr_ptr_r <= '0;
            grant_r  <= '0;
            drain_r  <= 1'b0;
            timer_r  <= '0;
            rdata_r  <= '0;
            err_r    <= 1'b0;
            addr_r   <= '0;
            wr_en_r  <= 1'b0;
            size_r   <= '0;
            wdata_r  <= '0;
        end else begin
            if (drain_r && plic_resp_v_i) begin
                drain_r <= 1'b0;
            end
            unique case (state_r)
                StIdle: begin
                    if (grant_ok) begin
                        grant_r <= win_id;
                        addr_r  <= req_addr_i[win_id*addr_width_p +: addr_width_p];
                        wr_en_r <= req_wr_en_i[win_id];
                        size_r  <= req_data_size_i[win_id*2 +: 2];
                        wdata_r <= req_wdata_i[win_id*data_width_p +: data_width_p];
                        state_r <= StCmd;
                    end
                end
                StCmd: begin
                    if (cmd_ready_and_i) begin
                        timer_r <= '0;
                        state_r <= StWait;
                    end
                end
                StWait: begin
                    // A response on the timeout cycle still counts as a normal answer.
                    if (plic_resp_v_i) begin
                        rdata_r <= plic_resp_rdata_i;
                        err_r   <= 1'b0;
                        state_r <= StResp;
                    end else if (timer_r == timer_last_lp) begin
                        rdata_r <= '1;
                        err_r   <= 1'b1;
                        drain_r <= 1'b1;
                        state_r <= StResp;
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end
                StResp: begin
                    if (resp_ready_and_i[grant_r]) begin
                        rr_ptr_r <= (grant_r == last_id_lp) ? '0 : grant_r + 1'b1;
                        state_r  <= StIdle;
                    end
                end
                default: state_r <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_plic_cmd_arbiter.sv
// Bench for plic_cmd_arbiter: directed vector table, corner sequences, then random traffic
// checked against a transaction-level model of arbitration, timeout and drain.
module tb_plic_cmd_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic        clk, rst_n;
    logic [1:0]  req_v, req_ready, req_wr, resp_v, resp_ready;
    logic [63:0] req_addr, req_wdata;
    logic [3:0]  req_size;
    logic [31:0] resp_rdata, cmd_addr, cmd_wdata, plic_rdata;
    logic        resp_err, cmd_v, cmd_ready, cmd_wr, plic_v, plic_ready;
    logic [1:0]  cmd_size;
    logic        grant_id;

    plic_cmd_arbiter #(
        .num_req_p(N), .addr_width_p(32), .data_width_p(32), .timeout_p(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_v_i(req_v), .req_ready_and_o(req_ready), .req_addr_i(req_addr),
        .req_wr_en_i(req_wr), .req_data_size_i(req_size), .req_wdata_i(req_wdata),
        .resp_v_o(resp_v), .resp_ready_and_i(resp_ready), .resp_rdata_o(resp_rdata),
        .resp_err_o(resp_err),
        .cmd_v_o(cmd_v), .cmd_ready_and_i(cmd_ready), .cmd_addr_o(cmd_addr),
        .cmd_wr_en_o(cmd_wr), .cmd_data_size_o(cmd_size), .cmd_wdata_o(cmd_wdata),
        .plic_resp_v_i(plic_v), .plic_resp_ready_and_o(plic_ready),
        .plic_resp_rdata_i(plic_rdata), .grant_id_o(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int r);
        oh = 2'b01 << r;
    endfunction

    task automatic set_payload(input int r, input logic [31:0] a, input logic w,
                               input logic [1:0] s, input logic [31:0] d);
        req_addr[r*32 +: 32]  = a;
        req_wr[r]             = w;
        req_size[r*2 +: 2]    = s;
        req_wdata[r*32 +: 32] = d;
    endtask

    typedef struct {
        int          r;
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          delay;     // PLIC answers this many edges after the command handshake
        int          exp_age;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int age;
        bit got, pdone, pnext;
        req_v = '0;
        plic_v = 1'b0;
        set_payload(v.r, v.addr, v.wr, v.size, v.wdata);
        req_v[v.r] = 1'b1;
        cmd_ready  = 1'b1;
        resp_ready = 2'b11;
        @(negedge clk);
        check("vec grant", req_ready, oh(v.r));
        check("vec cmd_v before grant", cmd_v, 1'b0);
        @(posedge clk); #1;
        req_v = '0;
        @(negedge clk);
        check("vec cmd_v", cmd_v, 1'b1);
        check("vec cmd_addr", cmd_addr, v.addr);
        check("vec cmd_wr", cmd_wr, v.wr);
        check("vec cmd_size", cmd_size, v.size);
        check("vec cmd_wdata", cmd_wdata, v.wdata);
        check("vec grant_id", grant_id, v.r[0]);
        @(posedge clk); #1;
        age = 0; got = 0; pdone = 0;
        for (int c = 0; c < 64 && !(got && pdone); c++) begin
            plic_v     = !pdone && (age >= v.delay - 1);
            plic_rdata = v.prdata;
            req_v      = '0;
            if (got && !pdone) req_v[1 - v.r] = 1'b1;
            @(negedge clk);
            pnext = plic_v && plic_ready;
            if (got && !pdone) check("drain blocks grant", req_ready, 2'b00);
            if (!got && resp_v != 2'b00) begin
                got = 1;
                check("vec resp_v", resp_v, oh(v.r));
                check("vec resp latency", age, v.exp_age);
                check("vec resp_rdata", resp_rdata, v.exp_rdata);
                check("vec resp_err", resp_err, v.exp_err);
            end
            @(posedge clk); #1;
            age++;
            if (pnext) pdone = 1;
        end
        tests++;
        if (!(got && pdone)) begin
            fails++;
            $display("FAIL vec completion: got resp=%0d plic_done=%0d expected both 1", got, pdone);
        end
        plic_v = 1'b0;
        req_v  = '0;
    endtask

    // Model state for the random phase
    int          phase, m_rr, m_grant, m_left, first, pl_age, pl_d, nresp, ngrant;
    bit          m_drain, m_err, hs_p, pl_busy, done;
    logic [31:0] m_rdata, m_addr, m_wdata, pl_data, nxt;
    logic        m_wr;
    logic [1:0]  m_size, exp_ready;
    bit          pend[2], waitr[2];
    logic [31:0] pa[2], pd[2];
    logic        pw[2];
    logic [1:0]  ps[2];

    initial begin
        vecs[0] = '{0, 32'h4,         1'b0, 2'd2, 32'h0,         32'h3,         3,  3,  1'b0, 32'h3};
        vecs[1] = '{1, 32'h2000_0004, 1'b1, 2'd2, 32'hDEAD_BEEF, 32'h0,         1,  1,  1'b0, 32'h0};
        vecs[2] = '{0, 32'h0C00_2000, 1'b0, 2'd2, 32'h0,         32'h7777_0000, 30, 16, 1'b1, 32'hFFFF_FFFF};
        vecs[3] = '{1, 32'h0C00_0008, 1'b0, 2'd1, 32'h0,         32'h55,        2,  2,  1'b0, 32'h55};
        vecs[4] = '{0, 32'h0C20_0004, 1'b0, 2'd2, 32'h0,         32'hA5A5_0001, 16, 16, 1'b0, 32'hA5A5_0001};
        vecs[5] = '{1, 32'h10,        1'b1, 2'd0, 32'h1,         32'h0,         17, 16, 1'b1, 32'hFFFF_FFFF};

        rst_n = 1'b0; req_v = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_size = '0;
        resp_ready = '0; cmd_ready = 1'b0; plic_v = 1'b0; plic_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset req_ready", req_ready, 2'b00);
        check("reset cmd_v", cmd_v, 1'b0);
        check("reset resp_v", resp_v, 2'b00);
        check("reset plic_ready", plic_ready, 1'b0);
        check("reset grant_id", grant_id, 1'b0);
        check("reset cmd_addr", cmd_addr, 32'h0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Contention: both always valid; rr pointer is 0 here
        set_payload(0, 32'h100, 1'b0, 2'd2, 32'h0);
        set_payload(1, 32'h200, 1'b0, 2'd2, 32'h0);
        req_v = 2'b11; cmd_ready = 1'b1; resp_ready = 2'b11; plic_v = 1'b1;
        nresp = 0; ngrant = 0; nxt = '0;
        for (int c = 0; c < 60 && nresp < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                check("contention grant", req_ready, oh(ngrant % 2));
                ngrant++;
            end
            if (cmd_v && cmd_ready) nxt = cmd_addr;
            if (resp_v != 2'b00) begin
                check("contention route", resp_v, oh(nresp % 2));
                check("contention rdata", resp_rdata, (nresp % 2) ? 32'h200 : 32'h100);
                nresp++;
            end
            @(posedge clk); #1;
            plic_rdata = nxt;
        end
        check("contention count", nresp, 4);
        req_v = '0; plic_v = 1'b0;

        // Backpressure on command and response paths
        set_payload(0, 32'h0C00_1004, 1'b1, 2'd2, 32'hCAFE_0001);
        set_payload(1, 32'h0C00_1008, 1'b0, 2'd2, 32'h0);
        req_v = 2'b01; cmd_ready = 1'b0; resp_ready = 2'b00;
        @(negedge clk);
        check("bp grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_v = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp cmd_v", cmd_v, 1'b1);
            check("bp cmd_addr", cmd_addr, 32'h0C00_1004);
            check("bp cmd_wdata", cmd_wdata, 32'hCAFE_0001);
            check("bp no grant cmd", req_ready, 2'b00);
            @(posedge clk); #1;
        end
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0; plic_v = 1'b1; plic_rdata = 32'h1234_5678;
        @(negedge clk);
        check("bp plic_ready", plic_ready, 1'b1);
        @(posedge clk); #1;
        plic_v = 1'b0; plic_rdata = 32'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp resp_v", resp_v, 2'b01);
            check("bp resp_rdata", resp_rdata, 32'h1234_5678);
            check("bp no grant resp", req_ready, 2'b00);
            @(posedge clk); #1;
        end
        resp_ready = 2'b01;
        @(posedge clk); #1;
        resp_ready = 2'b00;
        @(negedge clk);
        check("bp next grant", req_ready, 2'b10);
        @(posedge clk); #1;
        req_v = '0; cmd_ready = 1'b1; plic_v = 1'b1; plic_rdata = 32'hBEEF; resp_ready = 2'b11;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (resp_v != 2'b00) begin
                check("bp second resp", resp_v, 2'b10);
                done = 1;
            end
            @(posedge clk); #1;
        end
        check("bp second done", done, 1'b1);
        plic_v = 1'b0; cmd_ready = 1'b0;

        // Reset while waiting on the PLIC
        run_vec(vecs[0]);
        set_payload(1, 32'h0C00_0040, 1'b0, 2'd2, 32'h0);
        req_v = 2'b10; cmd_ready = 1'b1; resp_ready = 2'b11;
        @(posedge clk); #1;
        req_v = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst in wait", plic_ready, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst cmd_v", cmd_v, 1'b0);
        check("rst resp_v", resp_v, 2'b00);
        check("rst plic_ready", plic_ready, 1'b0);
        check("rst req_ready", req_ready, 2'b00);
        check("rst grant_id", grant_id, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_v = 2'b11;
        @(negedge clk);
        check("rst rr_ptr", req_ready, 2'b01);
        req_v = '0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rst no spurious resp", resp_v, 2'b00);
        end
        @(posedge clk); #1;

        // Random traffic against the transaction-level model
        phase = 0; m_rr = 0; m_grant = 0; m_drain = 0; pl_busy = 0; pl_age = 0; pl_d = 1;
        pl_data = '0; m_addr = '0; m_wdata = '0; m_wr = 0; m_size = '0; m_left = 0; m_err = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; waitr[i] = 0; pa[i] = '0; pd[i] = '0; pw[i] = 0; ps[i] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                req_v[i] = pend[i];
                set_payload(i, pa[i], pw[i], ps[i], pd[i]);
            end
            cmd_ready  = ($urandom_range(0, 3) != 0);
            resp_ready = 2'($urandom);
            plic_v     = pl_busy && (pl_age >= pl_d - 1);
            plic_rdata = pl_data;
            @(negedge clk);
            first = -1;
            for (int k = 0; k < N; k++) begin
                if (first < 0 && pend[(m_rr + k) % N]) first = (m_rr + k) % N;
            end
            exp_ready = (phase == 0 && !m_drain && first >= 0) ? oh(first) : 2'b00;
            check("rnd req_ready", req_ready, exp_ready);
            check("rnd cmd_v", cmd_v, phase == 1);
            if (phase == 1) begin
                check("rnd cmd_addr", cmd_addr, m_addr);
                check("rnd cmd_wr", cmd_wr, m_wr);
                check("rnd cmd_size", cmd_size, m_size);
                check("rnd cmd_wdata", cmd_wdata, m_wdata);
            end
            check("rnd plic_ready", plic_ready, (phase == 2) || m_drain);
            check("rnd resp_v", resp_v, (phase == 3) ? oh(m_grant) : 2'b00);
            if (phase == 3) begin
                check("rnd resp_rdata", resp_rdata, m_rdata);
                check("rnd resp_err", resp_err, m_err);
            end
            check("rnd grant_id", grant_id, m_grant[0]);

            hs_p = plic_v && ((phase == 2) || m_drain);
            if (hs_p) begin
                pl_busy = 0;
                m_drain = 0;
            end
            case (phase)
                0: if (exp_ready != 2'b00) begin
                    m_grant = first; m_addr = pa[first]; m_wr = pw[first];
                    m_size = ps[first]; m_wdata = pd[first];
                    pend[first] = 0; waitr[first] = 1; phase = 1;
                end
                1: if (cmd_ready) begin
                    pl_d = $urandom_range(1, 20); pl_busy = 1; pl_age = -1; pl_data = $urandom;
                    m_err = (pl_d > TO); m_left = m_err ? TO : pl_d; phase = 2;
                end
                2: begin
                    m_left--;
                    if (m_left == 0) begin
                        phase = 3;
                        m_rdata = m_err ? 32'hFFFF_FFFF : pl_data;
                        if (m_err) m_drain = 1;
                    end
                end
                default: if (resp_ready[m_grant]) begin
                    phase = 0; waitr[m_grant] = 0; m_rr = (m_grant + 1) % N;
                end
            endcase
            if (pl_busy) pl_age++;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && !waitr[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[i] = 1; pa[i] = $urandom; pd[i] = $urandom;
                        pw[i] = 1'($urandom); ps[i] = 2'($urandom);
                    end
                end else if (pend[i] && $urandom_range(0, 11) == 0) begin
                    pend[i] = 0;
                end
            end
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
